// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  localparam int LINE_W     = 128;
  localparam int WORD_W     = 32;
  localparam int OFFSET_W   = 4;
  localparam int MEM_ADDR_W = 28;

  function automatic logic [WORD_W-1:0] select_word(input logic [LINE_W-1:0] line,
                                                    input logic [1:0]        off);
    return line[off*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: synchronous install, async clear of valid bits,
// combinational read port.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int INDEX_W   = 3,
  parameter int TAG_W     = 25
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               we,
  input  logic [INDEX_W-1:0] widx,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [LINE_W-1:0]  wdata,
  input  logic               wvalid,
  input  logic [INDEX_W-1:0] ridx,
  output logic               rvalid,
  output logic [TAG_W-1:0]   rtag,
  output logic [LINE_W-1:0]  rdata
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  // An install in the flush cycle carries wvalid=0, so ordering here is benign.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      if (flush) valid_q <= '0;
      if (we)    valid_q[widx] <= wvalid;
    end
  end

  always_ff @(posedge clock) begin
    if (we) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wdata;
    end
  end

  assign rvalid = valid_q[ridx];
  assign rtag   = tag_q[ridx];
  assign rdata  = data_q[ridx];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller with zero-cycle hits and block refill.
// Optional hit/miss counters are enabled with ICACHE_PERF_CNT_EN.
module icache_controller
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int INDEX_W   = 3,
  parameter int TAG_W     = 25
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic [31:0]           address,
  input  logic                  flush,
  output logic [31:0]           instruction,
  output logic                  busywait,
  output logic                  mem_read,
  output logic [MEM_ADDR_W-1:0] mem_address,
  input  logic [LINE_W-1:0]     mem_readdata,
  input  logic                  mem_busywait
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  state_t                  state;
  logic                    wait_seen;
  logic                    flush_seen;
  logic [MEM_ADDR_W-1:0]   blk_addr;
  logic [LINE_W-1:0]       fill_data;

  logic [1:0]              word_off;
  logic [INDEX_W-1:0]      index;
  logic [TAG_W-1:0]        tag;
  logic                    line_valid;
  logic [TAG_W-1:0]        line_tag;
  logic [LINE_W-1:0]       line_data;
  logic                    hit;
  logic                    idle_hit;
  logic                    miss_start;
  logic                    fill_done;
  logic                    unused_addr;

  assign word_off    = address[3:2];
  assign index       = address[OFFSET_W +: INDEX_W];
  assign tag         = address[31 -: TAG_W];
  assign unused_addr = ^address[1:0];

  // A flush in the same cycle suppresses the hit so the read refetches.
  assign hit        = read & line_valid & (line_tag == tag) & ~flush;
  assign idle_hit   = (state == IDLE) & hit;
  assign miss_start = (state == IDLE) & read & ~hit;
  assign fill_done  = (state == MEM_READ) & wait_seen & ~mem_busywait;

  assign busywait    = reset & ((state != IDLE) | miss_start);
  assign instruction = (reset & idle_hit) ? select_word(line_data, word_off) : '0;
  assign mem_address = blk_addr;

  icache_line_array #(
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W)
  ) u_lines (
    .clock  (clock),
    .reset  (reset),
    .flush  (flush),
    .we     (state == UPDATE),
    .widx   (blk_addr[INDEX_W-1:0]),
    .wtag   (blk_addr[MEM_ADDR_W-1 -: TAG_W]),
    .wdata  (fill_data),
    .wvalid (~(flush_seen | flush)),
    .ridx   (index),
    .rvalid (line_valid),
    .rtag   (line_tag),
    .rdata  (line_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mem_read   <= 1'b0;
      wait_seen  <= 1'b0;
      flush_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_start) begin
            state      <= MEM_READ;
            mem_read   <= 1'b1;
            flush_seen <= 1'b0;
          end
        end
        MEM_READ: begin
          if (flush) flush_seen <= 1'b1;
          if (mem_busywait) begin
            wait_seen <= 1'b1;
          end else if (wait_seen) begin
            state    <= UPDATE;
            mem_read <= 1'b0;
          end
        end
        UPDATE: begin
          state      <= IDLE;
          wait_seen  <= 1'b0;
          flush_seen <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Fill address and returned block: the line is installed from these, not from the live PC.
  always_ff @(posedge clock) begin
    if (miss_start) blk_addr  <= address[31:OFFSET_W];
    if (fill_done)  fill_data <= mem_readdata;
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (idle_hit)   hit_count  <= hit_count + 32'd1;
      if (miss_start) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Scoreboard bench for icache_controller: expected words and block requests are
// queued at stimulus time and retired when the cache or the memory model responds.
module tb_icache_controller;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         read = 1'b0;
  logic [31:0]  address = '0;
  logic         flush = 1'b0;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata = '0;
  logic         mem_busywait = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  icache_controller dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .address      (address),
    .flush        (flush),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  logic [27:0] req_q[$];
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [27:0] blk, input logic [1:0] k);
    if (blk == 28'h0 && k == 2'd0) return 32'h00500093;
    return {4'hA, blk[23:0], 2'b00, k};
  endfunction

  function automatic logic [127:0] block_of(input logic [27:0] blk);
    return {word_of(blk, 2'd3), word_of(blk, 2'd2), word_of(blk, 2'd1), word_of(blk, 2'd0)};
  endfunction

  // Instruction memory: busy for three cycles after a request, then returns the block.
  int cnt = 0;
  bit active = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      active       = 1'b0;
      mem_busywait = 1'b0;
    end else if (!active) begin
      if (mem_read) begin
        active       = 1'b1;
        cnt          = 2;
        mem_busywait = 1'b1;
        if (req_q.size() == 0) check_eq("unexpected_req", {31'd0, mem_read}, 32'd0);
        else check_eq("mem_addr", {4'h0, mem_address}, {4'h0, req_q.pop_front()});
      end
    end else if (!mem_read) begin
      active       = 1'b0;
      mem_busywait = 1'b0;
    end else if (cnt > 0) begin
      cnt--;
    end else begin
      mem_busywait = 1'b0;
      mem_readdata = block_of(mem_address);
    end
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (busywait && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (busywait) check_eq({tag, "_timeout"}, {31'd0, busywait}, 32'd0);
    else if (exp_q.size() == 0) check_eq({tag, "_noexp"}, exp_q.size(), 32'd1);
    else check_eq(tag, instruction, exp_q.pop_front());
  endtask

  task automatic fetch(input logic [31:0] a, input bit miss, input string tag);
    @(posedge clock); #1;
    read    = 1'b1;
    address = a;
    exp_q.push_back(word_of(a[31:4], a[3:2]));
    if (miss) req_q.push_back(a[31:4]);
    @(negedge clock);
    check_eq({tag, "_busy"}, {31'd0, busywait}, {31'd0, miss});
    if (miss) begin
      @(negedge clock);
      check_eq({tag, "_mreq"}, {31'd0, mem_read}, 32'd1);
    end else begin
      check_eq({tag, "_nomreq"}, {31'd0, mem_read}, 32'd0);
    end
    wait_ready(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    read = 1'b1;
    repeat (2) @(negedge clock);
    check_eq("rst_busy", {31'd0, busywait}, 32'd0);
    check_eq("rst_mreq", {31'd0, mem_read}, 32'd0);
    check_eq("rst_instr", instruction, 32'h0);
    @(posedge clock); #1;
    read  = 1'b0;
    reset = 1'b1;

    fetch(32'h0, 1'b1, "cold");
    fetch(32'h4, 1'b0, "hit4");
    fetch(32'h8, 1'b0, "hit8");
    fetch(32'hC, 1'b0, "hitC");

    fetch(32'h80, 1'b1, "conflict");
    fetch(32'h84, 1'b0, "conflict_hit");
    fetch(32'h0, 1'b1, "evicted");

    // Retarget the PC while block 1 is being filled.
    @(posedge clock); #1;
    read    = 1'b1;
    address = 32'h10;
    req_q.push_back(28'h1);
    @(negedge clock);
    check_eq("chg_busy", {31'd0, busywait}, 32'd1);
    repeat (2) @(negedge clock);
    check_eq("chg_mreq", {31'd0, mem_read}, 32'd1);
    check_eq("chg_maddr", {4'h0, mem_address}, 32'h1);
    @(posedge clock); #1;
    address = 32'h20;
    req_q.push_back(28'h2);
    exp_q.push_back(word_of(28'h2, 2'd0));
    @(negedge clock);
    wait_ready("chg");
    fetch(32'h14, 1'b0, "chg_blk1");

    fetch(32'h0, 1'b0, "pre_flush");
    @(posedge clock); #1;
    read  = 1'b0;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    fetch(32'h0, 1'b1, "post_flush");

    // Flush together with a read that would otherwise hit.
    @(posedge clock); #1;
    read    = 1'b1;
    address = 32'h4;
    flush   = 1'b1;
    req_q.push_back(28'h0);
    exp_q.push_back(word_of(28'h0, 2'd1));
    @(negedge clock);
    check_eq("flrd_busy", {31'd0, busywait}, 32'd1);
    @(posedge clock); #1;
    flush = 1'b0;
    @(negedge clock);
    wait_ready("flrd");

    // Flush while the fill is outstanding: the fill lands invalid, so it refetches.
    @(posedge clock); #1;
    address = 32'h30;
    req_q.push_back(28'h3);
    req_q.push_back(28'h3);
    exp_q.push_back(word_of(28'h3, 2'd0));
    @(negedge clock);
    check_eq("flmid_busy", {31'd0, busywait}, 32'd1);
    repeat (2) @(negedge clock);
    @(posedge clock); #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    @(negedge clock);
    wait_ready("flmid");
    fetch(32'h34, 1'b0, "flmid_hit");

    @(posedge clock); #1;
    address = 32'h40;
    req_q.push_back(28'h4);
    repeat (3) @(negedge clock);
    check_eq("rstmid_mreq_pre", {31'd0, mem_read}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check_eq("rstmid_mreq", {31'd0, mem_read}, 32'd0);
    check_eq("rstmid_busy", {31'd0, busywait}, 32'd0);
    check_eq("rstmid_instr", instruction, 32'h0);
`ifdef ICACHE_PERF_CNT_EN
    check_eq("rst_hit_count", hit_count, 32'd0);
    check_eq("rst_miss_count", miss_count, 32'd0);
`endif
    read = 1'b0;
    repeat (2) @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    fetch(32'h0, 1'b1, "post_rst");

    repeat (4) @(negedge clock);
    check_eq("req_left", req_q.size(), 32'd0);
    check_eq("exp_left", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
